// File: rtl/imm_inst_encoder.sv
// Packs a register index and 32-bit immediate into RV32I instruction beats
// (LI -> LUI/ADDI, JAL, SW) over a valid/ready stream; faults emit a flagged NOP.
module imm_inst_encoder #(
  parameter bit SKIP_ZERO_ADDI = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_kind,
  input  logic [4:0]  i_req_rd,
  input  logic [4:0]  i_req_rs1,
  input  logic [31:0] i_req_imm,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic        o_inst_last,
  output logic        o_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst2_q, inst2_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  function automatic logic is_sext12(input logic [31:0] v);
    return v == {{20{v[11]}}, v[11:0]};
  endfunction

  function automatic logic is_sext21(input logic [31:0] v);
    return v == {{11{v[20]}}, v[20:0]};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] hi);
    return {hi, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  // Request decode: first word, optional second word, and fault detection.
  logic [31:0] w1_c, w2_c, hi_sum_c;
  logic        two_c, fault_c;

  always_comb begin
    w1_c     = NOP;
    w2_c     = NOP;
    two_c    = 1'b0;
    fault_c  = 1'b0;
    hi_sum_c = i_req_imm + 32'h0000_0800;
    case (i_req_kind)
      2'd0: begin
        if (is_sext12(i_req_imm)) begin
          w1_c = enc_addi(i_req_rd, 5'd0, i_req_imm[11:0]);
        end else begin
          w1_c  = enc_lui(i_req_rd, hi_sum_c[31:12]);
          w2_c  = enc_addi(i_req_rd, i_req_rd, i_req_imm[11:0]);
          two_c = !(SKIP_ZERO_ADDI && (i_req_imm[11:0] == 12'd0));
        end
      end
      2'd1: begin
        w1_c    = enc_jal(i_req_rd, i_req_imm);
        fault_c = i_req_imm[0] || !is_sext21(i_req_imm);
      end
      2'd2: begin
        w1_c    = enc_sw(i_req_rd, i_req_rs1, i_req_imm);
        fault_c = !is_sext12(i_req_imm);
      end
      default: fault_c = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    inst2_d = inst2_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          if (fault_c) begin
            state_d = ERR;
            inst_d  = NOP;
            last_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = BEAT1;
            inst_d  = w1_c;
            inst2_d = w2_c;
            last_d  = !two_c;
            err_d   = 1'b0;
          end
        end
      end
      BEAT1: begin
        if (i_inst_ready) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
            state_d = BEAT2;
            inst_d  = inst2_q;
            last_d  = 1'b1;
          end
        end
      end
      default: begin
        if (i_inst_ready) begin
          state_d = IDLE;
          last_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      inst_q  <= '0;
      inst2_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      inst2_q <= inst2_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign o_req_ready  = (state_q == IDLE);
  assign o_inst_valid = (state_q != IDLE);
  assign o_inst       = inst_q;
  assign o_inst_last  = last_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Directed bench for imm_inst_encoder with a queue scoreboard of expected beats.
module tb_imm_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_valid2 = 1'b0;
  logic        req_ready, req_ready2;
  logic [1:0]  req_kind = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0;
  logic [31:0] req_imm = '0;
  logic        inst_valid, inst_valid2;
  logic        inst_ready = 1'b0, inst_ready2 = 1'b0;
  logic [31:0] inst, inst2;
  logic        inst_last, inst_last2, err, err2;

  always #5 clk = ~clk;

  imm_inst_encoder #(.SKIP_ZERO_ADDI(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_kind(req_kind), .i_req_rd(req_rd), .i_req_rs1(req_rs1), .i_req_imm(req_imm),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready), .o_inst(inst),
    .o_inst_last(inst_last), .o_err(err)
  );

  imm_inst_encoder #(.SKIP_ZERO_ADDI(1'b0)) dut_noskip (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid2), .o_req_ready(req_ready2),
    .i_req_kind(req_kind), .i_req_rd(req_rd), .i_req_rs1(req_rs1), .i_req_imm(req_imm),
    .o_inst_valid(inst_valid2), .i_inst_ready(inst_ready2), .o_inst(inst2),
    .o_inst_last(inst_last2), .o_err(err2)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic        last;
    logic        err;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic l, input logic e);
    beat_t b;
    b.inst = i; b.last = l; b.err = e;
    sb.push_back(b);
  endtask

  task automatic send(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [31:0] imm);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_kind = k; req_rd = rd; req_rs1 = rs1; req_imm = imm;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Drain beats until the expected last beat, stalling the first beat `stall` cycles.
  task automatic collect(input string tag, input int stall);
    int    idle = 0;
    int    st = stall;
    beat_t e;
    forever begin
      @(negedge clk);
      if (sb.size() == 0) break;
      if (!inst_valid) begin
        idle++;
        if (idle > 20) begin
          chk({tag, "_beat_timeout"}, 32'd0, 32'd1);
          sb.delete();
          break;
        end
        continue;
      end
      e = sb[0];
      chk({tag, "_inst"}, inst, e.inst);
      chk({tag, "_last"}, {31'd0, inst_last}, {31'd0, e.last});
      chk({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
      chk({tag, "_req_ready_busy"}, {31'd0, req_ready}, 32'd0);
      if (st > 0) begin
        st--;
        continue;
      end
      inst_ready = 1'b1;
      void'(sb.pop_front());
      @(posedge clk);
      #1 inst_ready = 1'b0;
      if (e.last) begin
        @(negedge clk);
        chk({tag, "_req_ready_after"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_valid_after"}, {31'd0, inst_valid}, 32'd0);
        break;
      end
    end
  endtask

  initial begin
    #2;
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_last", {31'd0, inst_last}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    #10 rst_n = 1'b1;

    push(32'h123452B7, 1'b0, 1'b0); push(32'h67828293, 1'b1, 1'b0);
    send(2'd0, 5'd5, 5'd0, 32'h12345678); collect("li_x5", 0);

    push(32'hDEADC537, 1'b0, 1'b0); push(32'hEEF50513, 1'b1, 1'b0);
    send(2'd0, 5'd10, 5'd0, 32'hDEADBEEF); collect("li_stall", 3);

    push(32'hFFF00093, 1'b1, 1'b0);
    send(2'd0, 5'd1, 5'd0, 32'hFFFFFFFF); collect("li_m1", 0);

    push(32'h00010137, 1'b1, 1'b0);
    send(2'd0, 5'd2, 5'd0, 32'h00010000); collect("li_skip", 0);

    push(32'h7FF00193, 1'b1, 1'b0);
    send(2'd0, 5'd3, 5'd0, 32'h000007FF); collect("li_7ff", 0);

    push(32'h000011B7, 1'b0, 1'b0); push(32'h80018193, 1'b1, 1'b0);
    send(2'd0, 5'd3, 5'd0, 32'h00000800); collect("li_800", 0);

    push(32'h001000EF, 1'b1, 1'b0);
    send(2'd1, 5'd1, 5'd0, 32'h00000800); collect("jal_800", 0);

    push(32'h00000013, 1'b1, 1'b1);
    send(2'd1, 5'd1, 5'd0, 32'h00000003); collect("jal_odd", 0);

    push(32'h8000006F, 1'b1, 1'b0);
    send(2'd1, 5'd0, 5'd0, 32'hFFF00000); collect("jal_min", 0);

    push(32'h7FFFF0EF, 1'b1, 1'b0);
    send(2'd1, 5'd1, 5'd0, 32'h000FFFFE); collect("jal_max", 0);

    push(32'h00000013, 1'b1, 1'b1);
    send(2'd1, 5'd1, 5'd0, 32'h00100000); collect("jal_range", 0);

    push(32'hFE612E23, 1'b1, 1'b0);
    send(2'd2, 5'd6, 5'd2, 32'hFFFFFFFC); collect("sw_m4", 0);

    push(32'h00000013, 1'b1, 1'b1);
    send(2'd2, 5'd6, 5'd2, 32'h00000800); collect("sw_range", 0);

    push(32'h00000013, 1'b1, 1'b1);
    send(2'd3, 5'd1, 5'd1, 32'h00000000); collect("kind3", 2);

    // Second instance always emits the trailing ADDI.
    @(negedge clk);
    req_valid2 = 1'b1; req_kind = 2'd0; req_rd = 5'd2; req_imm = 32'h00010000;
    @(posedge clk);
    #1 req_valid2 = 1'b0; inst_ready2 = 1'b1;
    @(negedge clk);
    chk("noskip_b1_valid", {31'd0, inst_valid2}, 32'd1);
    chk("noskip_b1_inst", inst2, 32'h00010137);
    chk("noskip_b1_last", {31'd0, inst_last2}, 32'd0);
    @(negedge clk);
    chk("noskip_b2_inst", inst2, 32'h00010113);
    chk("noskip_b2_last", {31'd0, inst_last2}, 32'd1);
    chk("noskip_b2_err", {31'd0, err2}, 32'd0);
    @(negedge clk);
    inst_ready2 = 1'b0;
    chk("noskip_done", {31'd0, inst_valid2}, 32'd0);

    // Asynchronous reset while BEAT1 is stalled.
    send(2'd0, 5'd5, 5'd0, 32'h12345678);
    @(negedge clk);
    chk("rstmid_valid_before", {31'd0, inst_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rstmid_valid_async", {31'd0, inst_valid}, 32'd0);
    chk("rstmid_inst", inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid_no_beat2", {31'd0, inst_valid}, 32'd0);
    end
    chk("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
    inst_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
